cmp_sched: RTL and testbench
============================

Name: cmp_sched

Overview:
- Sequencer for the bitmap compare accelerator: scores one candidate glyph against a bank of stored template bitmaps and reports the best match.
- For each template it streams 64-bit words from template memory and assembles a 1536-bit bitmap.
- It then pulses the accelerator's write enable, waits for done, captures the 16-bit score, and tracks the best score and its index.
- Sits between the control CPU (start/abort/status) and the compare accelerator plus template ROM.

Parameters:
- NUM_TMPL, 16, number of templates scanned per run (≥1).
- IDX_W, 4, width of template index; 2^IDX_W ≥ NUM_TMPL.
- ADDR_W, 9, template memory word-address width; 2^ADDR_W ≥ NUM_TMPL*24.
- TIMEOUT_CYC, 4096, max cycles waited for accelerator done per template.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- abort  in  1  synchronous cancel of the current run.
- busy  out  1  high from cycle after accepted start until run ends.
- done  out  1  one-cycle pulse when a run completes normally.
- best_idx  out  IDX_W  index of best-scoring template from the last completed run.
- best_score  out  16  score of that template.
- timeout_err  out  1  sticky: some template in the last/current run timed out.
- tmpl_rd  out  1  template memory read enable.
- tmpl_addr  out  ADDR_W  word address = tmpl*24 + word.
- tmpl_rdata  in  64  read data, valid exactly 1 cycle after tmpl_rd.
- acc_wren  out  1  one-cycle load strobe to accelerator.
- acc_bitmap  out  1536  assembled template bitmap.
- acc_result  in  16  accelerator score.
- acc_done  in  1  accelerator completion (level or pulse).

Behaviour:
- Reset: all outputs 0, including acc_bitmap, best_*, timeout_err; state IDLE; running regs cleared.
- States: IDLE, FETCH, LOAD, GUARD, WAIT, SCORE, FIN.
- IDLE: start=1 → FETCH; tmpl=0; run_best=0, run_idx=0; timeout_err cleared; busy=1 next cycle.
- FETCH, 25 cycles: cycles 0..23 assert tmpl_rd with word k = 0..23; cycles 1..24 capture tmpl_rdata into acc_bitmap[64k+63:64k]. → LOAD.
- LOAD: acc_wren=1 for exactly 1 cycle. acc_bitmap held constant from LOAD until next FETCH capture. → GUARD.
- GUARD: 1 cycle; acc_done ignored, which masks a stale done level. → WAIT.
- WAIT: cycle counter from 1.
  - acc_done=1 → SCORE with score=acc_result.
  - Counter reaches TIMEOUT_CYC without done → SCORE with score=0 and timeout_err set to 1.
- SCORE, 1 cycle:
  - If score > run_best, or tmpl==0: run_best=score, run_idx=tmpl.
  - Ties keep the lower index (strict >).
  - If tmpl==NUM_TMPL-1 → FIN, else tmpl++ → FETCH.
- FIN: best_idx←run_idx, best_score←run_best, done=1 for one cycle, busy=0 same cycle → IDLE.
- Per-template latency: 25+1+1+W+1 cycles, where W = WAIT cycles including the cycle done is sampled.
- start while not IDLE: ignored.
- start and abort together in IDLE: abort wins, no run.
- abort in any non-IDLE state: → IDLE next cycle, with busy=0, tmpl_rd=0, acc_wren=0, and no done pulse. best_idx/best_score keep the prior completed run's values; timeout_err retains its value.
- rst mid-run: identical to the reset state above. The accelerator has no reset; the GUARD cycle protects the first load after reset.
- tmpl_addr = 0 when tmpl_rd=0.
- Arithmetic: score compare is unsigned 16-bit; timeout counter width is clog2(TIMEOUT_CYC+1).

Test Plan:
- Reset: assert rst 3 cycles mid-FETCH → all outputs 0, busy=0, no acc_wren afterwards without start.
- Normal run, NUM_TMPL=4, model returns 10,40,25,40, done after W=3:
  - Addresses issued 0..95 in order.
  - acc_wren pulses 4 times.
  - done pulse at cycle 4*(28+3)+1 after start.
  - best_idx=1, best_score=40, timeout_err=0.
- Bitmap assembly: ROM word k = {56'h0, 8'(k)} → acc_bitmap at LOAD has byte k at bits [64k+7:64k] for k=0..23.
- Timeout, TIMEOUT_CYC=8, template 2 never done:
  - WAIT lasts 8 cycles and template 2 scores 0.
  - timeout_err=1 and the run completes.
  - With scores 5,3,-,2: best_idx=0, best_score=5.
- Abort in WAIT of template 1 after a prior run gave (idx 3, score 77) → busy=0 next cycle, no done, best_idx=3, best_score=77. A fresh start then completes correctly.
- start pulsed during FETCH and SCORE → ignored, with a single done per run. Stale acc_done held high through LOAD/GUARD → not sampled before WAIT.

Source files
------------

// File: rtl/cmp_sched.sv
// cmp_sched: scans a bank of template bitmaps through the compare
// accelerator and reports the best-scoring template index and score.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; last completed result held on best_*
// FETCH  | 25 cycles: reads words 0..23, captures each one cycle later
// LOAD   | one-cycle acc_wren strobe with the assembled bitmap
// GUARD  | one cycle with acc_done ignored (masks a stale done level)
// WAIT   | waits for acc_done, gives up after TIMEOUT_CYC cycles
// SCORE  | folds the score into the running best, next template or FIN
// FIN    | publishes the result with a one-cycle done pulse

module cmp_sched #(
  parameter int NUM_TMPL    = 16,
  parameter int IDX_W       = 4,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  best_idx,
  output logic [15:0]       best_score,
  output logic              timeout_err,
  output logic              tmpl_rd,
  output logic [ADDR_W-1:0] tmpl_addr,
  input  logic [63:0]       tmpl_rdata,
  output logic              acc_wren,
  output logic [1535:0]     acc_bitmap,
  input  logic [15:0]       acc_result,
  input  logic              acc_done
);

  localparam int WORDS = 24;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_TMPL = IDX_W'(NUM_TMPL - 1);
  localparam logic [4:0]       LAST_WORD = 5'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_GUARD, S_WAIT, S_SCORE, S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          word_q, word_d;
  logic [IDX_W-1:0]    tmpl_q, tmpl_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [15:0]         score_q, score_d;
  logic [15:0]         run_best_q, run_best_d;
  logic [IDX_W-1:0]    run_idx_q, run_idx_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [15:0]         best_score_q, best_score_d;
  logic                timeout_err_q, timeout_err_d;
  logic [1535:0]       bitmap_q, bitmap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmpl_rd_q, tmpl_rd_d;
  logic [ADDR_W-1:0]   tmpl_addr_q, tmpl_addr_d;
  logic                acc_wren_q, acc_wren_d;

  // Next-state logic; outputs are derived from the next state so they
  // are registered yet line up with the state they belong to.
  // rd_ptr walks tmpl*24+word contiguously across the whole run.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    tmpl_d        = tmpl_q;
    rd_ptr_d      = rd_ptr_q;
    to_cnt_d      = to_cnt_q;
    score_d       = score_q;
    run_best_d    = run_best_q;
    run_idx_d     = run_idx_q;
    best_idx_d    = best_idx_q;
    best_score_d  = best_score_q;
    timeout_err_d = timeout_err_q;
    bitmap_d      = bitmap_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_FETCH;
          word_d        = '0;
          tmpl_d        = '0;
          rd_ptr_d      = '0;
          run_best_d    = '0;
          run_idx_d     = '0;
          timeout_err_d = 1'b0;
        end
      end
      S_FETCH: begin
        for (int k = 0; k < WORDS; k++) begin
          if (word_q == 5'(k + 1)) bitmap_d[k*64 +: 64] = tmpl_rdata;
        end
        if (word_q < LAST_WORD) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (word_q == LAST_WORD) state_d = S_LOAD;
        else                     word_d  = word_q + 5'd1;
      end
      S_LOAD: begin
        state_d = S_GUARD;
      end
      S_GUARD: begin
        state_d  = S_WAIT;
        to_cnt_d = TO_W'(TIMEOUT_CYC);
      end
      S_WAIT: begin
        if (acc_done) begin
          score_d = acc_result;
          state_d = S_SCORE;
        end else if (to_cnt_q == TO_W'(1)) begin
          score_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = S_SCORE;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      S_SCORE: begin
        if ((score_q > run_best_q) || (tmpl_q == '0)) begin
          run_best_d = score_q;
          run_idx_d  = tmpl_q;
        end
        if (tmpl_q == LAST_TMPL) begin
          state_d      = S_FIN;
          best_idx_d   = run_idx_d;
          best_score_d = run_best_d;
        end else begin
          tmpl_d  = tmpl_q + IDX_W'(1);
          word_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the run without touching the published result or the
    // sticky timeout flag.
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      best_idx_d    = best_idx_q;
      best_score_d  = best_score_q;
      timeout_err_d = timeout_err_q;
    end

    busy_d      = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d      = (state_d == S_FIN);
    acc_wren_d  = (state_d == S_LOAD);
    tmpl_rd_d   = (state_d == S_FETCH) && (word_d < LAST_WORD);
    tmpl_addr_d = tmpl_rd_d ? rd_ptr_d : '0;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      tmpl_q        <= '0;
      rd_ptr_q      <= '0;
      to_cnt_q      <= '0;
      score_q       <= '0;
      run_best_q    <= '0;
      run_idx_q     <= '0;
      best_idx_q    <= '0;
      best_score_q  <= '0;
      timeout_err_q <= 1'b0;
      bitmap_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tmpl_rd_q     <= 1'b0;
      tmpl_addr_q   <= '0;
      acc_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      tmpl_q        <= tmpl_d;
      rd_ptr_q      <= rd_ptr_d;
      to_cnt_q      <= to_cnt_d;
      score_q       <= score_d;
      run_best_q    <= run_best_d;
      run_idx_q     <= run_idx_d;
      best_idx_q    <= best_idx_d;
      best_score_q  <= best_score_d;
      timeout_err_q <= timeout_err_d;
      bitmap_q      <= bitmap_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tmpl_rd_q     <= tmpl_rd_d;
      tmpl_addr_q   <= tmpl_addr_d;
      acc_wren_q    <= acc_wren_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign best_idx    = best_idx_q;
  assign best_score  = best_score_q;
  assign timeout_err = timeout_err_q;
  assign tmpl_rd     = tmpl_rd_q;
  assign tmpl_addr   = tmpl_addr_q;
  assign acc_wren    = acc_wren_q;
  assign acc_bitmap  = bitmap_q;

endmodule

// File: tb/tb_cmp_sched.sv
// Bench for cmp_sched: run table plus abort/reset/start corner sequences.
module tb_cmp_sched;

  localparam int NT = 4;
  localparam int IW = 4;
  localparam int AW = 9;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, timeout_err, tmpl_rd, acc_wren;
  logic [IW-1:0] best_idx;
  logic [15:0]   best_score;
  logic [AW-1:0] tmpl_addr;
  logic [63:0]   tmpl_rdata = '0;
  logic [1535:0] acc_bitmap;
  logic [15:0]   acc_result = '0;
  logic          acc_done = 1'b0;

  cmp_sched #(.NUM_TMPL(NT), .IDX_W(IW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .best_idx(best_idx), .best_score(best_score), .timeout_err(timeout_err),
    .tmpl_rd(tmpl_rd), .tmpl_addr(tmpl_addr), .tmpl_rdata(tmpl_rdata),
    .acc_wren(acc_wren), .acc_bitmap(acc_bitmap), .acc_result(acc_result),
    .acc_done(acc_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] sc;
    logic [3:0]       never;
    int               dly;
    bit               stale;
    logic [3:0]       e_idx;
    logic [15:0]      e_score;
    bit               e_to;
  } vec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] score;
    bit          to;
    int          lat;
    int          c0;
  } sb_t;

  vec_t tbl[9];
  sb_t  sb[$];

  logic [3:0][15:0] cur_sc = '0;
  logic [3:0]       cur_never = '0;
  int               cur_dly = 4;
  bit               cur_stale = 1'b0;
  int               cur_t = 0;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int wren_cnt = 0;
  int exp_addr = 0;
  int last_wren = 0;
  int d = 255;
  logic          prev_rd = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input logic [3:0] nv, input int dl, input bit st,
                              input int ei, input int es, input bit et);
    vec_t v;
    v.sc[0] = 16'(s0); v.sc[1] = 16'(s1); v.sc[2] = 16'(s2); v.sc[3] = 16'(s3);
    v.never = nv; v.dly = dl; v.stale = st;
    v.e_idx = 4'(ei); v.e_score = 16'(es); v.e_to = et;
    return v;
  endfunction

  function automatic logic [63:0] rom(input logic [AW-1:0] a);
    logic [AW-1:0] k;
    k = a % AW'(24);
    return {40'h0, 7'h0, a, k[7:0]};
  endfunction

  function automatic logic [1535:0] exp_bm(input int t);
    logic [1535:0] b;
    for (int k = 0; k < 24; k++) b[k*64 +: 64] = rom(AW'(t*24 + k));
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_bm(input string nm, input int t);
    logic [1535:0] e;
    int wk;
    e = exp_bm(t);
    n_vec++;
    if (acc_bitmap !== e) begin
      n_bad++;
      wk = 0;
      for (int k = 23; k >= 0; k--) if (acc_bitmap[k*64 +: 64] !== e[k*64 +: 64]) wk = k;
      $display("FAIL %s tmpl %0d word %0d: got %h expected %h", nm, t, wk,
               acc_bitmap[wk*64 +: 64], e[wk*64 +: 64]);
    end
  endtask

  // Template ROM, accelerator model and output monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    tmpl_rdata = prev_rd ? rom(prev_addr) : 64'hBADC_0FFE_E0DD_F00D;
    prev_rd    = tmpl_rd;
    prev_addr  = tmpl_addr;

    if (acc_wren) begin
      if (!rst) begin
        chk_bm("bitmap_at_load", wren_cnt & 3);
        if (wren_cnt > 0)
          chk("wren_gap", 64'(cyc - last_wren),
              64'(28 + (cur_never[(wren_cnt-1) & 3] ? TO : cur_dly - 1)));
      end
      cur_t     = wren_cnt & 3;
      last_wren = cyc;
      wren_cnt++;
      d = 0;
    end else if (d < 255) begin
      d++;
    end
    acc_done   = ((d == cur_dly) && !cur_never[cur_t]) || (cur_stale && (d <= 1));
    acc_result = (d == cur_dly) ? cur_sc[cur_t] : 16'hFFFF;

    if (!rst) begin
      if (tmpl_rd) begin
        chk("tmpl_addr", 64'(tmpl_addr), 64'(exp_addr));
        exp_addr++;
      end else begin
        chk("tmpl_addr_idle", 64'(tmpl_addr), 64'h0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'h1, 64'h0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("best_idx", 64'(best_idx), 64'(e.idx));
          chk("best_score", 64'(best_score), 64'(e.score));
          chk("timeout_err", 64'(timeout_err), 64'(e.to));
          chk("done_latency", 64'(cyc - e.c0), 64'(e.lat));
          chk("addr_count", 64'(exp_addr), 64'(NT*24));
          chk("wren_count", 64'(wren_cnt), 64'(NT));
          chk("busy_at_done", 64'(busy), 64'h0);
          chk_bm("bitmap_held", NT-1);
        end
      end
    end
  end

  task automatic set_cur(input int i);
    cur_sc = tbl[i].sc; cur_never = tbl[i].never;
    cur_dly = tbl[i].dly; cur_stale = tbl[i].stale;
    wren_cnt = 0; exp_addr = 0;
  endtask

  task automatic run_vec(input int i, input bit extra);
    sb_t e;
    int lat;
    @(negedge clk);
    set_cur(i);
    lat = 1;
    for (int t = 0; t < NT; t++) lat += 28 + (tbl[i].never[t] ? TO : tbl[i].dly - 1);
    e.idx = tbl[i].e_idx; e.score = tbl[i].e_score; e.to = tbl[i].e_to;
    e.lat = lat; e.c0 = cyc;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'h1);
    chk("to_err_cleared", 64'(timeout_err), 64'h0);
    if (extra) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (27 + tbl[i].dly - 6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int n = 0; n < 3000 && sb.size() > 0; n++) @(negedge clk);
    chk("run_finished", 64'(sb.size()), 64'h0);
    sb.delete();
    repeat (3) @(negedge clk);
    if (extra) begin
      repeat (40) @(negedge clk);
      chk("no_extra_run", 64'(busy), 64'h0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_best_idx"}, 64'(best_idx), 0);
    chk({tag, "_best_score"}, 64'(best_score), 0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 0);
    chk({tag, "_tmpl_rd"}, 64'(tmpl_rd), 0);
    chk({tag, "_tmpl_addr"}, 64'(tmpl_addr), 0);
    chk({tag, "_acc_wren"}, 64'(acc_wren), 0);
    chk({tag, "_bitmap_nz"}, 64'(|acc_bitmap), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //            s0     s1   s2   s3     never   dly st  idx score   to
    tbl[0] = mk(10,    40,  25,  40,    4'b0000, 4, 0, 1, 40,    0);
    tbl[1] = mk(5,     3,   99,  2,     4'b0100, 4, 0, 0, 5,     1);
    tbl[2] = mk(0,     0,   0,   0,     4'b0000, 2, 0, 0, 0,     0);
    tbl[3] = mk(1,     2,   3,   65535, 4'b0000, 9, 0, 3, 65535, 0);
    tbl[4] = mk(300,   200, 300, 299,   4'b0000, 4, 1, 0, 300,   0);
    tbl[5] = mk(65535, 7,   7,   7,     4'b1111, 4, 0, 0, 0,     1);
    tbl[6] = mk(10,    20,  30,  77,    4'b0000, 4, 0, 3, 77,    0);
    tbl[7] = mk(9,     8,   7,   6,     4'b0000, 3, 0, 0, 9,     0);
    tbl[8] = mk(1,     2,   3,   4,     4'b0000, 6, 0, 0, 0,     0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, 1'b0);

    // Abort in WAIT of template 1 (dly 6: template 1 WAIT spans c0+61..65).
    @(negedge clk);
    set_cur(8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (61) @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 1);
    chk("pre_abort_wren_cnt", 64'(wren_cnt), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_tmpl_rd", 64'(tmpl_rd), 0);
    chk("abort_acc_wren", 64'(acc_wren), 0);
    chk("abort_best_idx", 64'(best_idx), 3);
    chk("abort_best_score", 64'(best_score), 77);
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", 64'(busy), 0);

    // Fresh run after abort, with start pulses during FETCH and SCORE.
    run_vec(7, 1'b1);

    // Reset held 3 cycles mid-FETCH.
    @(negedge clk);
    set_cur(8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("midrun_reset");
    rst = 1'b0;
    wren_cnt = 0;
    repeat (40) @(negedge clk);
    chk("post_reset_no_wren", 64'(wren_cnt), 0);
    chk("post_reset_busy", 64'(busy), 0);

    // start and abort together in IDLE: no run.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 0);
    repeat (30) @(negedge clk);
    chk("start_abort_no_wren", 64'(wren_cnt), 0);

    run_vec(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
